rx_packet_ctrl_module: RTL and testbench
========================================

// Module: rx_packet_ctrl_module
// PURPOSE
//   Sequences the UART receive path (Rx_module) to assemble framed packets.
//   - Drives RX_En_Sig and consumes each RX_Done_Sig/RX_Data byte.
//   - Parses the frame [HEADER][LEN][payload x LEN][CSUM] and streams payload bytes downstream.
//   - Flags packet completion or error: checksum, length, inter-byte timeout.
// PARAMETERS
//   HEADER        8'hAA    start-of-frame byte
//   MAX_LEN       16       largest legal LEN value (1..255)
//   TIMEOUT       500000   max idle cycles between bytes inside a frame (10 ms @ 50 MHz)
//   TO_W          19       timeout counter width; must satisfy 2**TO_W > TIMEOUT
// PORTS
//   CLK            in   1  system clock
//   RST            in   1  reset
//   Enable_Sig     in   1  1 = accept packets
//   RX_Done_Sig    in   1  one-cycle pulse from Rx_module: a byte is on RX_Data
//   RX_Data        in   8  received byte; valid while RX_Done_Sig = 1
//   RX_En_Sig      out  1  receive enable to Rx_module
//   Payload_Data   out  8  payload byte
//   Payload_Valid  out  1  one-cycle strobe: Payload_Data is valid
//   Pkt_Done_Sig   out  1  one-cycle strobe: frame passed the checksum
//   Pkt_Err_Sig    out  1  one-cycle strobe: frame rejected
//   Err_Code       out  2  01 = checksum, 10 = length, 11 = timeout; held until the next error
//   Busy           out  1  1 while in LEN, PAYLOAD or CSUM
// BEHAVIOUR
//   Clocking/reset: one clock; reset is asynchronous and active-high.
//   Reset state: state = IDLE; all outputs 0; len, count, sum and timer cleared.
//   Register/latency rules:
//   - All outputs are registered.
//   - Strobes and Payload_Data appear exactly 1 cycle after the RX_Done_Sig that caused them.
//   RX_En_Sig: 1 in every state except IDLE; forced 0 for one cycle after each RX_Done_Sig (restart).
//   FSM:
//   - IDLE: Enable_Sig = 1 -> HUNT.
//   - HUNT:
//     - Enable_Sig = 0 -> IDLE.
//     - byte == HEADER -> LEN.
//     - any other byte is discarded silently.
//   - LEN:
//     - byte == 0 or byte > MAX_LEN -> Pkt_Err, Err_Code = 10, -> HUNT.
//     - otherwise len = byte, sum = byte, count = 0, -> PAYLOAD.
//   - PAYLOAD, per byte:
//     - Payload_Data = byte; Payload_Valid pulses.
//     - sum = (sum + byte) mod 256; count += 1.
//     - count reaches len -> CSUM.
//   - CSUM:
//     - byte == sum -> Pkt_Done; otherwise Pkt_Err, Err_Code = 01.
//     - Then -> HUNT if Enable_Sig = 1, else IDLE.
//   Payload forwarding: bytes are forwarded before the checksum is known. Downstream discards the frame on Pkt_Err_Sig.
//   Timeout (LEN, PAYLOAD, CSUM only):
//   - Timer clears on entering LEN and on every RX_Done_Sig; it increments otherwise.
//   - timer == TIMEOUT-1 with no RX_Done_Sig -> Pkt_Err, Err_Code = 11, -> HUNT.
//   Simultaneous events and boundaries:
//   - RX_Done_Sig in the same cycle as timeout terminal count: the byte wins; no error.
//   - Enable_Sig dropped mid-frame: the frame completes; then IDLE.
//   - RX_Done_Sig while in IDLE: ignored.
//   - LEN == MAX_LEN is legal; LEN == MAX_LEN+1 is rejected.
//   - Pkt_Done_Sig and Pkt_Err_Sig are never high together.
//   - Busy = 0 the cycle after any terminal strobe.
//   Reset mid-operation: immediate return to reset state; the partial frame is dropped with no strobe.
// TESTING
//   1. En = 1; bytes AA 03 10 20 30 63 -> Payload_Valid x3 (10, 20, 30); Pkt_Done 1 cycle after 0x63.
//   2. Bytes AA 03 10 20 30 64 -> 3 payload strobes, then Pkt_Err with Err_Code = 01; FSM back in HUNT.
//   3. Bytes 55 00 AA 00 -> 55 and 00 ignored, then Pkt_Err with Err_Code = 10.
//      Also AA 10 ... accepted; AA 11 -> Err_Code = 10.
//   4. Bytes AA 02 11, then silence -> Pkt_Err with Err_Code = 11 exactly TIMEOUT cycles after the 0x11 done.
//      Then AA 01 05 06 -> Pkt_Done.
//   5. RX_Done_Sig forced on the timeout terminal cycle -> byte accepted; no Pkt_Err.
//   6. Assert RST during payload -> all outputs 0 and state IDLE the same cycle.
//      With En = 0, RX_Done_Sig pulses produce no strobes and RX_En_Sig stays 0.

Source files
------------

// File: rtl/rx_packet_ctrl_module.sv
// Packet framer behind a UART receiver: hunts for HEADER, reads LEN, streams payload,
// verifies an 8-bit additive checksum and reports completion, errors and inter-byte timeouts.
module rx_packet_ctrl_module #(
  parameter logic [7:0]  HEADER  = 8'hAA,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 500000,
  parameter int unsigned TO_W    = 19
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Enable_Sig,
  input  logic       RX_Done_Sig,
  input  logic [7:0] RX_Data,
  output logic       RX_En_Sig,
  output logic [7:0] Payload_Data,
  output logic       Payload_Valid,
  output logic       Pkt_Done_Sig,
  output logic       Pkt_Err_Sig,
  output logic [1:0] Err_Code,
  output logic       Busy
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StHunt    = 3'd1;
  localparam logic [2:0] StLen     = 3'd2;
  localparam logic [2:0] StPayload = 3'd3;
  localparam logic [2:0] StCsum    = 3'd4;

  localparam logic [1:0] ErrCsum    = 2'b01;
  localparam logic [1:0] ErrLen     = 2'b10;
  localparam logic [1:0] ErrTimeout = 2'b11;

  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

  logic [2:0]      state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      count_q, count_d;
  logic [7:0]      sum_q, sum_d;
  logic [TO_W-1:0] timer_q, timer_d;

  logic [7:0] data_d;
  logic       valid_d, done_d, err_d, rx_en_d, busy_d;
  logic [1:0] code_d;

  logic       in_frame;
  logic       byte_rx;
  logic       timeout;
  logic       len_bad;
  logic [7:0] count_inc;
  logic [7:0] sum_add;

  assign in_frame  = (state_q == StLen) || (state_q == StPayload) || (state_q == StCsum);
  assign byte_rx   = RX_Done_Sig && (state_q != StIdle);
  // A byte arriving on the terminal count cycle takes priority over the timeout.
  assign timeout   = in_frame && !RX_Done_Sig && (timer_q == ToLast);
  assign len_bad   = (RX_Data == 8'd0) || ({24'd0, RX_Data} > MAX_LEN);
  assign count_inc = count_q + 8'd1;
  assign sum_add   = sum_q + RX_Data;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    sum_d   = sum_q;
    data_d  = Payload_Data;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = Err_Code;

    if (in_frame && !RX_Done_Sig) begin
      timer_d = timer_q + TO_W'(1);
    end else begin
      timer_d = '0;
    end

    case (state_q)
      StIdle: begin
        if (Enable_Sig) begin
          state_d = StHunt;
        end
      end
      StHunt: begin
        if (!Enable_Sig) begin
          state_d = StIdle;
        end else if (RX_Done_Sig && (RX_Data == HEADER)) begin
          state_d = StLen;
        end
      end
      StLen: begin
        if (RX_Done_Sig) begin
          if (len_bad) begin
            err_d   = 1'b1;
            code_d  = ErrLen;
            state_d = StHunt;
          end else begin
            len_d   = RX_Data;
            sum_d   = RX_Data;
            count_d = 8'd0;
            state_d = StPayload;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          code_d  = ErrTimeout;
          state_d = StHunt;
        end
      end
      StPayload: begin
        if (RX_Done_Sig) begin
          data_d  = RX_Data;
          valid_d = 1'b1;
          sum_d   = sum_add;
          count_d = count_inc;
          if (count_inc == len_q) begin
            state_d = StCsum;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          code_d  = ErrTimeout;
          state_d = StHunt;
        end
      end
      StCsum: begin
        if (RX_Done_Sig) begin
          if (RX_Data == sum_q) begin
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ErrCsum;
          end
          state_d = Enable_Sig ? StHunt : StIdle;
        end else if (timeout) begin
          err_d   = 1'b1;
          code_d  = ErrTimeout;
          state_d = StHunt;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Receiver is paused for one cycle after every accepted byte so it can re-arm.
    rx_en_d = (state_d != StIdle) && !byte_rx;
    busy_d  = (state_d == StLen) || (state_d == StPayload) || (state_d == StCsum);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= StIdle;
      len_q         <= 8'd0;
      count_q       <= 8'd0;
      sum_q         <= 8'd0;
      timer_q       <= '0;
      RX_En_Sig     <= 1'b0;
      Payload_Data  <= 8'd0;
      Payload_Valid <= 1'b0;
      Pkt_Done_Sig  <= 1'b0;
      Pkt_Err_Sig   <= 1'b0;
      Err_Code      <= 2'b00;
      Busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      count_q       <= count_d;
      sum_q         <= sum_d;
      timer_q       <= timer_d;
      RX_En_Sig     <= rx_en_d;
      Payload_Data  <= data_d;
      Payload_Valid <= valid_d;
      Pkt_Done_Sig  <= done_d;
      Pkt_Err_Sig   <= err_d;
      Err_Code      <= code_d;
      Busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_rx_packet_ctrl_module.sv
// Bench for rx_packet_ctrl_module: frame-level stimulus pushes expected strobes into a
// scoreboard; a forked monitor pops and compares each strobe, its cycle and side signals.
module tb_rx_packet_ctrl_module;

  localparam int unsigned TIMEOUT = 40;
  localparam int unsigned MAX_LEN = 16;
  localparam int KNone = -1;
  localparam int KPay  = 0;
  localparam int KDone = 1;
  localparam int KErr  = 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Enable_Sig;
  logic       RX_Done_Sig;
  logic [7:0] RX_Data;
  logic       RX_En_Sig;
  logic [7:0] Payload_Data;
  logic       Payload_Valid;
  logic       Pkt_Done_Sig;
  logic       Pkt_Err_Sig;
  logic [1:0] Err_Code;
  logic       Busy;

  rx_packet_ctrl_module #(
    .HEADER (8'hAA),
    .MAX_LEN(MAX_LEN),
    .TIMEOUT(TIMEOUT),
    .TO_W   (6)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .Enable_Sig   (Enable_Sig),
    .RX_Done_Sig  (RX_Done_Sig),
    .RX_Data      (RX_Data),
    .RX_En_Sig    (RX_En_Sig),
    .Payload_Data (Payload_Data),
    .Payload_Valid(Payload_Valid),
    .Pkt_Done_Sig (Pkt_Done_Sig),
    .Pkt_Err_Sig  (Pkt_Err_Sig),
    .Err_Code     (Err_Code),
    .Busy         (Busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   last_edge = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // One received byte; the expected strobe (if any) lands on the edge that samples it.
  task automatic send_byte(input logic [7:0] b, input int idle, input int kind, input int val);
    repeat (idle) @(negedge CLK);
    @(negedge CLK);
    RX_Data     = b;
    RX_Done_Sig = 1'b1;
    last_edge   = cyc + 1;
    if (kind != KNone) exp_q.push_back('{kind: kind, val: val, cyc: last_edge});
    @(negedge CLK);
    RX_Done_Sig = 1'b0;
  endtask

  task automatic send_junk(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == 8'hAA) b = 8'h55;
      send_byte(b, $urandom_range(0, 3), KNone, 0);
    end
  endtask

  // Complete frame with random payload; checksum = (LEN + sum of payload) mod 256.
  task automatic good_frame(input int len, input bit corrupt);
    logic [7:0] sum;
    logic [7:0] b;
    send_byte(8'hAA, $urandom_range(0, 3), KNone, 0);
    send_byte(8'(len), $urandom_range(0, 3), KNone, 0);
    sum = 8'(len);
    for (int i = 0; i < len; i++) begin
      b   = 8'($urandom);
      sum = sum + b;
      send_byte(b, $urandom_range(0, 3), KPay, int'(b));
    end
    if (corrupt) begin
      b = sum ^ (8'd1 << $urandom_range(0, 7));
      send_byte(b, $urandom_range(0, 3), KErr, 1);
    end else begin
      send_byte(sum, $urandom_range(0, 3), KDone, 0);
    end
  endtask

  // Frame cut short after `sent` bytes past the header (0 = header only), then silence.
  task automatic timeout_frame(input int len, input int sent);
    logic [7:0] b;
    send_byte(8'hAA, $urandom_range(0, 3), KNone, 0);
    if (sent > 0) send_byte(8'(len), $urandom_range(0, 3), KNone, 0);
    for (int i = 1; i < sent; i++) begin
      b = 8'($urandom);
      send_byte(b, $urandom_range(0, 3), KPay, int'(b));
    end
    exp_q.push_back('{kind: KErr, val: 3, cyc: last_edge + int'(TIMEOUT)});
    repeat (TIMEOUT + 3) @(negedge CLK);
  endtask

  task automatic monitor();
    exp_t e;
    int   k;
    int   v;
    forever begin
      @(negedge CLK);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_strobe: got nothing, required kind %0d value %0d at cycle %0d",
                 e.kind, e.val, e.cyc);
      end
      if (!RST && (Payload_Valid || Pkt_Done_Sig || Pkt_Err_Sig)) begin
        check("done_err_exclusive", int'(Pkt_Done_Sig && Pkt_Err_Sig), 0);
        k = Pkt_Err_Sig ? KErr : (Pkt_Done_Sig ? KDone : KPay);
        v = (k == KPay) ? int'(Payload_Data) : ((k == KErr) ? int'(Err_Code) : 0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got kind %0d value %0d at cycle %0d, required none",
                   k, v, cyc);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", k, e.kind);
          check("strobe_value", v, e.val);
          check("strobe_cycle", cyc, e.cyc);
          check("busy_at_strobe", int'(Busy), int'(k == KPay));
          check("rx_en_at_strobe", int'(RX_En_Sig), int'(k == KErr && e.val == 3));
        end
      end
    end
  endtask

  initial begin
    logic [7:0] sum;
    logic [7:0] b;
    int         kind;
    int         len;

    RST         = 1'b1;
    Enable_Sig  = 1'b0;
    RX_Done_Sig = 1'b0;
    RX_Data     = 8'h00;
    fork
      monitor();
    join_none

    repeat (3) @(negedge CLK);
    check("reset_rx_en", int'(RX_En_Sig), 0);
    check("reset_busy", int'(Busy), 0);
    check("reset_err_code", int'(Err_Code), 0);
    check("reset_strobes", int'({Payload_Valid, Pkt_Done_Sig, Pkt_Err_Sig}), 0);
    check("reset_payload_data", int'(Payload_Data), 0);
    RST        = 1'b0;
    Enable_Sig = 1'b1;
    repeat (2) @(negedge CLK);
    check("hunt_rx_en", int'(RX_En_Sig), 1);
    check("hunt_busy", int'(Busy), 0);

    // Good frame and checksum error.
    send_byte(8'hAA, 0, KNone, 0);
    send_byte(8'h03, 1, KNone, 0);
    check("len_busy", int'(Busy), 1);
    send_byte(8'h10, 1, KPay, 8'h10);
    send_byte(8'h20, 0, KPay, 8'h20);
    send_byte(8'h30, 2, KPay, 8'h30);
    send_byte(8'h63, 0, KDone, 0);
    send_byte(8'hAA, 1, KNone, 0);
    send_byte(8'h03, 0, KNone, 0);
    send_byte(8'h10, 0, KPay, 8'h10);
    send_byte(8'h20, 0, KPay, 8'h20);
    send_byte(8'h30, 0, KPay, 8'h30);
    send_byte(8'h64, 0, KErr, 1);

    // Junk before the header, zero length, MAX_LEN accepted, MAX_LEN+1 rejected.
    send_byte(8'h55, 1, KNone, 0);
    send_byte(8'h00, 1, KNone, 0);
    send_byte(8'hAA, 1, KNone, 0);
    send_byte(8'h00, 1, KErr, 2);
    send_byte(8'hAA, 1, KNone, 0);
    send_byte(8'(MAX_LEN), 0, KNone, 0);
    sum = 8'(MAX_LEN);
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      b   = 8'(i * 7 + 3);
      sum = sum + b;
      send_byte(b, 0, KPay, int'(b));
    end
    send_byte(sum, 0, KDone, 0);
    send_byte(8'hAA, 1, KNone, 0);
    send_byte(8'(MAX_LEN + 1), 0, KErr, 2);

    // Inter-byte timeout, then recovery; the timeout code is held across a good frame.
    send_byte(8'hAA, 1, KNone, 0);
    send_byte(8'h02, 1, KNone, 0);
    send_byte(8'h11, 1, KPay, 8'h11);
    exp_q.push_back('{kind: KErr, val: 3, cyc: last_edge + int'(TIMEOUT)});
    repeat (TIMEOUT + 3) @(negedge CLK);
    send_byte(8'hAA, 0, KNone, 0);
    send_byte(8'h01, 0, KNone, 0);
    send_byte(8'h05, 0, KPay, 8'h05);
    send_byte(8'h06, 0, KDone, 0);
    check("err_code_held", int'(Err_Code), 3);

    // Byte on the terminal-count cycle wins; one cycle later the timeout has fired.
    send_byte(8'hAA, 1, KNone, 0);
    send_byte(8'h02, 1, KNone, 0);
    send_byte(8'h11, 1, KPay, 8'h11);
    send_byte(8'h22, TIMEOUT - 2, KPay, 8'h22);
    send_byte(8'h35, 0, KDone, 0);
    send_byte(8'hAA, 1, KNone, 0);
    send_byte(8'h02, 1, KNone, 0);
    send_byte(8'h11, 1, KPay, 8'h11);
    exp_q.push_back('{kind: KErr, val: 3, cyc: last_edge + int'(TIMEOUT)});
    send_byte(8'h22, TIMEOUT - 1, KNone, 0);
    repeat (3) @(negedge CLK);

    // Randomized frames.
    for (int p = 0; p < 30; p++) begin
      kind = $urandom_range(0, 5);
      len  = ($urandom_range(0, 4) == 0) ? int'(MAX_LEN) : $urandom_range(1, MAX_LEN);
      send_junk($urandom_range(0, 2));
      case (kind)
        0, 1, 2: good_frame(len, 1'b0);
        3:       good_frame(len, 1'b1);
        4: begin
          send_byte(8'hAA, $urandom_range(0, 3), KNone, 0);
          b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
          send_byte(b, $urandom_range(0, 3), KErr, 2);
        end
        default: timeout_frame(len, $urandom_range(0, len + 1));
      endcase
    end

    // Enable dropped mid-frame: frame completes, then the receiver is parked.
    send_byte(8'hAA, 1, KNone, 0);
    send_byte(8'h02, 1, KNone, 0);
    Enable_Sig = 1'b0;
    send_byte(8'h01, 1, KPay, 8'h01);
    send_byte(8'h02, 1, KPay, 8'h02);
    send_byte(8'h05, 1, KDone, 0);
    repeat (2) @(negedge CLK);
    check("idle_rx_en", int'(RX_En_Sig), 0);
    check("idle_busy", int'(Busy), 0);
    send_byte(8'hAA, 1, KNone, 0);
    send_byte(8'h01, 1, KNone, 0);
    check("idle_ignores_bytes", int'(Busy), 0);
    Enable_Sig = 1'b1;
    repeat (2) @(negedge CLK);
    check("rehunt_rx_en", int'(RX_En_Sig), 1);

    // Asynchronous reset mid-payload drops the frame immediately.
    send_byte(8'hAA, 1, KNone, 0);
    send_byte(8'h04, 1, KNone, 0);
    send_byte(8'h01, 1, KPay, 8'h01);
    send_byte(8'h02, 0, KPay, 8'h02);
    #2;
    RST        = 1'b1;
    Enable_Sig = 1'b0;
    #1;
    check("midrst_payload_valid", int'(Payload_Valid), 0);
    check("midrst_payload_data", int'(Payload_Data), 0);
    check("midrst_busy", int'(Busy), 0);
    check("midrst_rx_en", int'(RX_En_Sig), 0);
    check("midrst_err_code", int'(Err_Code), 0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_byte((i == 0) ? 8'hAA : 8'(i), 1, KNone, 0);
      check("disabled_rx_en", int'(RX_En_Sig), 0);
    end

    repeat (5) @(negedge CLK);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
